// File: rtl/fadd_arbiter_if.sv
// Request/response/adder bundle for fadd_arbiter. The stat_* counters exist only
// when FADD_ARB_STATS_EN is defined.
interface fadd_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_s;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_s;
    logic [DATA_W-1:0] fa_a;
    logic [DATA_W-1:0] fa_b;
    logic [DATA_W-1:0] fa_s;
    logic              busy;
`ifdef FADD_ARB_STATS_EN
    logic [15:0]       stat_grant0;
    logic [15:0]       stat_grant1;
    logic [15:0]       stat_stall;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               rsp0_ready, rsp1_ready, fa_s,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_s, rsp1_valid, rsp1_s,
               fa_a, fa_b, busy
`ifdef FADD_ARB_STATS_EN
        , input stat_grant0, stat_grant1, stat_stall
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               rsp0_ready, rsp1_ready, fa_s,
        output req0_ready, req1_ready, rsp0_valid, rsp0_s, rsp1_valid, rsp1_s,
               fa_a, fa_b, busy
`ifdef FADD_ARB_STATS_EN
        , output stat_grant0, stat_grant1, stat_stall
`endif
    );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin, credit-based sharing of one LAT-cycle pipelined float adder between two
// requesters, with a tag pipeline and per-requester response FIFOs. Optional FADD_ARB_STATS_EN.
module fadd_arbiter #(
    parameter int DATA_W     = 32,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fadd_arbiter_if.slave bus
);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SLOTS = 1 << PW;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [5:0]    cnt_t;

    localparam cnt_t DEPTH_C    = cnt_t'(FIFO_DEPTH);
    localparam ptr_t LAST_PTR_C = ptr_t'(FIFO_DEPTH - 1);

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        if (p == LAST_PTR_C) begin
            n = {PW{1'b0}};
        end else begin
            n = p + ptr_t'(1'b1);
        end
        return n;
    endfunction

    logic [DATA_W-1:0] fa_a_r;
    logic [DATA_W-1:0] fa_b_r;
    logic [LAT-1:0]    tag_valid_r;
    logic [LAT-1:0]    tag_id_r;
    logic              last_grant_r;
    logic [DATA_W-1:0] mem_r    [2][SLOTS];
    ptr_t              rd_ptr_r [2];
    ptr_t              wr_ptr_r [2];
    cnt_t              count_r  [2];

    logic [1:0]        req_valid_s;
    logic [1:0]        rsp_ready_s;
    logic [1:0]        eligible_s;
    logic [1:0]        grant_s;
    logic [1:0]        push_s;
    logic [1:0]        pop_s;
    logic [1:0]        nonempty_s;
    cnt_t              inflight_s [2];
    logic              xfer_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;

    assign req_valid_s = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready_s = {bus.rsp1_ready, bus.rsp0_ready};

    // Credit check: buffered plus in-flight results must leave room in the requester's FIFO
    always_comb begin
        inflight_s[0] = 6'd0;
        inflight_s[1] = 6'd0;
        for (int k = 0; k < LAT; k++) begin
            inflight_s[0] = inflight_s[0] + {5'd0, tag_valid_r[k] & ~tag_id_r[k]};
            inflight_s[1] = inflight_s[1] + {5'd0, tag_valid_r[k] &  tag_id_r[k]};
        end
        for (int n = 0; n < 2; n++) begin
            eligible_s[n] = req_valid_s[n] && ((count_r[n] + inflight_s[n]) < DEPTH_C);
        end
    end

    // Round-robin grant; the requester that did not win last time has priority
    always_comb begin
        grant_s = 2'b00;
        if (rst) begin
            grant_s[0] = eligible_s[0] & (~eligible_s[1] |  last_grant_r);
            grant_s[1] = eligible_s[1] & (~eligible_s[0] | ~last_grant_r);
        end else begin
            grant_s = 2'b00;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a_s = bus.req0_a;
        sel_b_s = bus.req0_b;
        if (grant_s[1]) begin
            sel_a_s = bus.req1_a;
            sel_b_s = bus.req1_b;
        end else begin
            sel_a_s = bus.req0_a;
            sel_b_s = bus.req0_b;
        end
    end

    assign xfer_s        = |grant_s;
    assign push_s[0]     = tag_valid_r[LAT-1] & ~tag_id_r[LAT-1];
    assign push_s[1]     = tag_valid_r[LAT-1] &  tag_id_r[LAT-1];
    assign nonempty_s[0] = (count_r[0] != 6'd0);
    assign nonempty_s[1] = (count_r[1] != 6'd0);
    assign pop_s         = nonempty_s & rsp_ready_s;

    // Operand registers, tag pipeline and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fa_a_r       <= {DATA_W{1'b0}};
            fa_b_r       <= {DATA_W{1'b0}};
            tag_valid_r  <= {LAT{1'b0}};
            tag_id_r     <= {LAT{1'b0}};
            last_grant_r <= 1'b1;
            for (int n = 0; n < 2; n++) begin
                rd_ptr_r[n] <= {PW{1'b0}};
                wr_ptr_r[n] <= {PW{1'b0}};
                count_r[n]  <= 6'd0;
            end
        end else begin
            if (xfer_s) begin
                fa_a_r       <= sel_a_s;
                fa_b_r       <= sel_b_s;
                last_grant_r <= grant_s[1];
            end
            tag_valid_r[0] <= xfer_s;
            tag_id_r[0]    <= grant_s[1];
            for (int k = 1; k < LAT; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_id_r[k]    <= tag_id_r[k-1];
            end
            for (int n = 0; n < 2; n++) begin
                if (push_s[n]) begin
                    wr_ptr_r[n] <= ptr_inc(wr_ptr_r[n]);
                end
                if (pop_s[n]) begin
                    rd_ptr_r[n] <= ptr_inc(rd_ptr_r[n]);
                end
                count_r[n] <= count_r[n] + {5'd0, push_s[n]} - {5'd0, pop_s[n]};
            end
        end
    end

    // FIFO storage; no reset needed because emptiness is tracked by count_r
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push_s[n]) begin
                mem_r[n][wr_ptr_r[n]] <= bus.fa_s;
            end
        end
    end

    assign bus.fa_a       = fa_a_r;
    assign bus.fa_b       = fa_b_r;
    assign bus.req0_ready = grant_s[0];
    assign bus.req1_ready = grant_s[1];
    assign bus.rsp0_valid = nonempty_s[0];
    assign bus.rsp1_valid = nonempty_s[1];
    assign bus.rsp0_s     = nonempty_s[0] ? mem_r[0][rd_ptr_r[0]] : {DATA_W{1'b0}};
    assign bus.rsp1_s     = nonempty_s[1] ? mem_r[1][rd_ptr_r[1]] : {DATA_W{1'b0}};
    assign bus.busy       = (|tag_valid_r) | nonempty_s[0] | nonempty_s[1];

`ifdef FADD_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        logic [15:0] r;
        if (en && (v != 16'hFFFF)) begin
            r = v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [15:0] stat_grant0_r;
    logic [15:0] stat_grant1_r;
    logic [15:0] stat_stall_r;
    logic        stall_s;

    assign stall_s = (|req_valid_s) & ~xfer_s;

    // Saturating grant and stall counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grant0_r <= 16'd0;
            stat_grant1_r <= 16'd0;
            stat_stall_r  <= 16'd0;
        end else begin
            stat_grant0_r <= sat_inc(stat_grant0_r, grant_s[0]);
            stat_grant1_r <= sat_inc(stat_grant1_r, grant_s[1]);
            stat_stall_r  <= sat_inc(stat_stall_r, stall_s);
        end
    end

    assign bus.stat_grant0 = stat_grant0_r;
    assign bus.stat_grant1 = stat_grant1_r;
    assign bus.stat_stall  = stat_stall_r;
`endif
endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter: a FIFO_DEPTH=2 instance for arbitration, backpressure and
// reset, and a FIFO_DEPTH=8 instance for full-rate streaming, each fed by a table-based adder model.
module tb_fadd_arbiter;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_arbiter_if #(.DATA_W(32)) bus ();
    fadd_arbiter_if #(.DATA_W(32)) busb ();

    fadd_arbiter #(.DATA_W(32), .LAT(LAT), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fadd_arbiter #(.DATA_W(32), .LAT(LAT), .FIFO_DEPTH(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (busb)
    );

    // Single-precision sums of the operand pairs used here
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        case ({a, b})
            {32'h4e32a8b6, 32'hce9b8a1f}: s = 32'hce046b88;
            {32'h4d905610, 32'h4c3c1864}: s = 32'h4da7d91c;
            {32'hce28495b, 32'hce904f23}: s = 32'hcee473d0;
            {32'h4ea27aab, 32'hce9ff632}: s = 32'h4ba11e40;
            {32'hcd6f9230, 32'h4e0e5d70}: s = 32'h4da4f1c8;
            {32'hce55e840, 32'h4c65a940}: s = 32'hce478dac;
            default:                      s = a ^ b;
        endcase
        return s;
    endfunction

    // Adder pipelines: fa_s reflects fa_a/fa_b loaded LAT-1 edges earlier, sampled on the LAT-th
    logic [31:0] pa [LAT-1];
    logic [31:0] pb [LAT-1];
    always @(posedge clk) begin
        pa[0] <= fadd(bus.fa_a, bus.fa_b);
        pb[0] <= fadd(busb.fa_a, busb.fa_b);
        for (int k = 1; k < LAT - 1; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end
    assign bus.fa_s  = pa[LAT-2];
    assign busb.fa_s = pb[LAT-2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic who, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            bus.req1_valid = v;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end else begin
            bus.req0_valid = v;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end
    endtask

    // One isolated operation on the depth-2 instance; both response ports held ready
    task automatic single_issue(input string name, input logic who, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] s);
        drive_req(who, 1'b1, a, b);
        #1;
        check_bit({name, " ready"}, who ? bus.req1_ready : bus.req0_ready, 1'b1);
        step();
        drive_req(who, 1'b0, a, b);
        for (int k = 1; k <= LAT; k++) begin
            step();
            #1;
            check_bit({name, " rsp_valid latency"}, who ? bus.rsp1_valid : bus.rsp0_valid, k == LAT);
            if (k == 1) check_bit({name, " busy in flight"}, bus.busy, 1'b1);
        end
        check({name, " rsp_s"}, who ? bus.rsp1_s : bus.rsp0_s, s);
        check_bit({name, " other port idle"}, who ? bus.rsp0_valid : bus.rsp1_valid, 1'b0);
        step();
        #1;
        check_bit({name, " popped"}, who ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
        check_bit({name, " busy after pop"}, bus.busy, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic        who;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0, acc1, r0_after, r0, r1, stalls, alt_err, dual, prev;
        logic first;

        vecs[0] = '{"single r0 a",  1'b0, 32'h4e32a8b6, 32'hce9b8a1f, 32'hce046b88};
        vecs[1] = '{"single r1 a",  1'b1, 32'h4d905610, 32'h4c3c1864, 32'h4da7d91c};
        vecs[2] = '{"single r0 b",  1'b0, 32'hce28495b, 32'hce904f23, 32'hcee473d0};
        vecs[3] = '{"single r1 b",  1'b1, 32'hcd6f9230, 32'h4e0e5d70, 32'h4da4f1c8};
        vecs[4] = '{"single r0 c",  1'b0, 32'h4ea27aab, 32'hce9ff632, 32'h4ba11e40};

        rst = 1'b0;
        drive_req(1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 32'd0, 32'd0);
        bus.rsp0_ready  = 1'b1;
        bus.rsp1_ready  = 1'b1;
        busb.req0_valid = 1'b0;
        busb.req0_a     = 32'd0;
        busb.req0_b     = 32'd0;
        busb.req1_valid = 1'b0;
        busb.req1_a     = 32'd0;
        busb.req1_b     = 32'd0;
        busb.rsp0_ready = 1'b1;
        busb.rsp1_ready = 1'b1;
        repeat (3) step();
        #1;
        check("reset fa_a", bus.fa_a, 32'd0);
        check_bit("reset rsp0_valid", bus.rsp0_valid, 1'b0);
        check_bit("reset busy", bus.busy, 1'b0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            single_issue(vecs[i].name, vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].s);
        end

        // Backpressure: requester 1 stalls its response port
        bus.rsp1_ready = 1'b0;
        acc0 = 0; acc1 = 0; r0_after = 0;
        for (int c = 0; c < 24; c++) begin
            drive_req(1'b0, 1'b1, 32'h4d905610, 32'h4c3c1864);
            drive_req(1'b1, 1'b1, 32'h4ea27aab, 32'hce9ff632);
            #1;
            if (bus.req1_ready) acc1++;
            if (bus.req0_ready) begin
                acc0++;
                if (acc1 >= 2) r0_after++;
            end
            if (bus.rsp0_valid) check("bp rsp0 data", bus.rsp0_s, 32'h4da7d91c);
            step();
        end
        drive_req(1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 32'd0, 32'd0);
        check("bp req1 accepts", acc1, 32'd2);
        check_bit("bp req0 continues", r0_after >= 2, 1'b1);
        repeat (8) step();
        #1;
        check_bit("bp rsp1 held valid", bus.rsp1_valid, 1'b1);
        bus.rsp1_ready = 1'b1;
        check("bp rsp1 first", bus.rsp1_s, 32'h4ba11e40);
        step();
        #1;
        check_bit("bp rsp1 second valid", bus.rsp1_valid, 1'b1);
        check("bp rsp1 second", bus.rsp1_s, 32'h4ba11e40);
        step();
        #1;
        check_bit("bp rsp1 drained", bus.rsp1_valid, 1'b0);
        check_bit("bp busy drained", bus.busy, 1'b0);

        // Throughput on the depth-8 instance: accepts in cycles 0..7, results in cycles 5..12
        for (int c = 0; c < 16; c++) begin
            busb.req0_valid = (c < 8);
            busb.req0_a     = 32'hcd6f9230;
            busb.req0_b     = 32'h4e0e5d70;
            #1;
            check_bit("tp ready", busb.req0_ready, c < 8);
            check_bit("tp rsp valid", busb.rsp0_valid, (c >= 5) && (c < 13));
            if (busb.rsp0_valid) check("tp rsp data", busb.rsp0_s, 32'h4da4f1c8);
            step();
        end
        busb.req0_valid = 1'b0;

        // Reset with three operations in flight
        acc0 = 0;
        for (int c = 0; c < 3; c++) begin
            drive_req(1'b0, 1'b1, 32'h4e32a8b6, 32'hce9b8a1f);
            drive_req(1'b1, 1'b1, 32'h4d905610, 32'h4c3c1864);
            #1;
            if (bus.req0_ready || bus.req1_ready) acc0++;
            step();
        end
        drive_req(1'b1, 1'b0, 32'd0, 32'd0);
        check("rst ops issued", acc0, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("rst fa_a", bus.fa_a, 32'd0);
        check("rst fa_b", bus.fa_b, 32'd0);
        check_bit("rst rsp0_valid", bus.rsp0_valid, 1'b0);
        check_bit("rst rsp1_valid", bus.rsp1_valid, 1'b0);
        check("rst rsp0_s", bus.rsp0_s, 32'd0);
        check("rst rsp1_s", bus.rsp1_s, 32'd0);
        check_bit("rst busy", bus.busy, 1'b0);
        check_bit("rst req0_ready forced", bus.req0_ready, 1'b0);
        step();
        #1;
        check_bit("rst req0_ready held", bus.req0_ready, 1'b0);
        drive_req(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        rst = 1'b1;
`ifdef FADD_ARB_STATS_EN
        #1;
        check("rst stat_grant0", bus.stat_grant0, 32'd0);
        check("rst stat_stall", bus.stat_stall, 32'd0);
`endif
        r0 = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            #1;
            if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) r0++;
        end
        check("post-reset stale activity", r0, 32'd0);

        // Contention: 10 ops each, round-robin under depth-2 credit throttling
        acc0 = 0; acc1 = 0; r0 = 0; r1 = 0;
        stalls = 0; alt_err = 0; dual = 0; prev = 0; first = 1'b1;
        for (int c = 0; c < 80 && (r0 < 10 || r1 < 10); c++) begin
            drive_req(1'b0, acc0 < 10, 32'h4d905610, 32'h4c3c1864);
            drive_req(1'b1, acc1 < 10, 32'hce28495b, 32'hce904f23);
            #1;
            if (bus.req0_ready && bus.req1_ready) dual++;
            if (bus.req0_ready || bus.req1_ready) begin
                if (first) check_bit("ct first grant is r0", bus.req0_ready, 1'b1);
                else if (int'(bus.req1_ready) == prev) alt_err++;
                first = 1'b0;
                prev  = int'(bus.req1_ready);
                if (bus.req1_ready) acc1++;
                else acc0++;
            end else if (bus.req0_valid || bus.req1_valid) begin
                stalls++;
            end
            if (bus.rsp0_valid) begin
                check("ct rsp0 data", bus.rsp0_s, 32'h4da7d91c);
                r0++;
            end
            if (bus.rsp1_valid) begin
                check("ct rsp1 data", bus.rsp1_s, 32'hcee473d0);
                r1++;
            end
            step();
        end
        drive_req(1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 32'd0, 32'd0);
        check("ct r0 accepts", acc0, 32'd10);
        check("ct r1 accepts", acc1, 32'd10);
        check("ct r0 results", r0, 32'd10);
        check("ct r1 results", r1, 32'd10);
        check("ct alternation errors", alt_err, 32'd0);
        check("ct double grants", dual, 32'd0);
        check("ct blocked cycles", stalls, 32'd8);
`ifdef FADD_ARB_STATS_EN
        #1;
        check("stat_grant0", bus.stat_grant0, 32'd10);
        check("stat_grant1", bus.stat_grant1, 32'd10);
        check("stat_stall", bus.stat_stall, 32'd8);
`endif
        step();

        single_issue("post-reset r0", 1'b0, 32'hce55e840, 32'h4c65a940, 32'hce478dac);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
